// File: rtl/nearest_upsampling_layer.sv
// Nearest-neighbour N x upsampler for a row-major pixel stream, with downstream stall.
// Define UPSAMPLE_ZERO_INSERT_EN to insert zeros (unpooling) instead of replicating.
module nearest_upsampling_layer #(
  parameter int unsigned N           = 2,
  parameter int unsigned ImageWidth  = 2,
  parameter int unsigned ImageHeight = 2,
  parameter int unsigned BitSize     = 32
) (
  input  logic               clk,
  input  logic               res,
  input  logic               in_valid,
  input  logic [BitSize-1:0] in_data,
  output logic               out_ready,
  input  logic               in_ready,
  output logic               out_valid,
  output logic [BitSize-1:0] out_data,
  output logic               out_done
);

  localparam int unsigned ColW = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int unsigned RowW = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(ImageWidth - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ImageHeight - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic {FILL, REPLAY} state_e;

  state_e             state_q, state_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [CntW-1:0]    h_cnt_q, h_cnt_d;
  logic [CntW-1:0]    v_cnt_q, v_cnt_d;
  logic [BitSize-1:0] hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               out_done_q, out_done_d;
  logic               accept, xfer, row_end;
  logic [BitSize-1:0] fill_data, replay_data;

`ifdef UPSAMPLE_ZERO_INSERT_EN
  // Only the top-left sample of each N x N block carries data.
  assign fill_data   = (h_cnt_q == '0) ? hold_q : '0;
  assign replay_data = '0;
`else
  logic [BitSize-1:0] row_buf_q [ImageWidth];
  logic [ColW-1:0]    buf_idx;

  // A pixel accepted alongside the previous pixel's last replica belongs to the next column.
  assign buf_idx     = hold_valid_q ? col_q + ColW'(1) : col_q;
  assign fill_data   = hold_q;
  assign replay_data = row_buf_q[col_q];

  always_ff @(posedge clk) begin
    if (accept) row_buf_q[buf_idx] <= in_data;
  end
`endif

  assign out_done = out_done_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      out_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      out_done_q   <= out_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    out_done_d   = 1'b0;
    out_ready    = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    row_end      = 1'b0;

    if (state_q == FILL) begin
      out_valid = hold_valid_q;
      out_data  = fill_data;
      out_ready = !res && (!hold_valid_q ||
                           (in_ready && h_cnt_q == CntLast && col_q != ColLast));
    end else begin
      out_valid = 1'b1;
      out_data  = replay_data;
    end

    accept = in_valid && out_ready;
    xfer   = out_valid && in_ready;

    // Replica / column / pass stepping on each output transfer.
    if (xfer) begin
      if (h_cnt_q != CntLast) begin
        h_cnt_d = h_cnt_q + CntW'(1);
      end else begin
        h_cnt_d = '0;
        if (state_q == FILL) hold_valid_d = 1'b0;
        if (col_q != ColLast) begin
          col_d = col_q + ColW'(1);
        end else begin
          col_d = '0;
          if (state_q == FILL) begin
            if (N > 1) begin
              state_d = REPLAY;
              v_cnt_d = CntW'(1);
            end else begin
              row_end = 1'b1;
            end
          end else if (v_cnt_q != CntLast) begin
            v_cnt_d = v_cnt_q + CntW'(1);
          end else begin
            row_end = 1'b1;
          end
        end
      end
    end

    if (row_end) begin
      state_d = FILL;
      v_cnt_d = '0;
      if (row_q == RowLast) begin
        row_d      = '0;
        out_done_d = 1'b1;
      end else begin
        row_d = row_q + RowW'(1);
      end
    end

    if (accept) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
      h_cnt_d      = '0;
    end
  end

endmodule
